// File: rtl/sdram_port_arbiter.sv
// -----------------------------------------------------------------------------
// sdram_port_arbiter
//
// Purpose:
//   Two-requester arbiter and sequencer in front of the user-area SDRAM
//   controller. Port 0 (Wishbone slave path) and port 1 (DMA / prefetch
//   master) share the controller's single command interface. One transaction
//   runs at a time. Simultaneous requests are resolved round-robin. Every
//   controller-side output is driven straight from a flop.
//
// Optional feature:
//   SDRAM_ARB_TIMEOUT_EN - when defined, a read that gets no ctrl_out_valid
//   within TO_CYCLES cycles completes with 0xDEAD_BEEF and a one-cycle err
//   pulse that coincides with the ack. When undefined, err is tied low and a
//   read waits indefinitely.
//
// Ports:
//   clk, rst          single clock, synchronous active-high reset
//   reqN_valid        request from port N, held until reqN_ack
//   reqN_we           1 = write, 0 = read
//   reqN_addr/wdata   request address / write data
//   reqN_ack          one-cycle completion pulse
//   reqN_rdata        read data; valid while reqN_ack=1 and held between acks
//   ctrl_addr/rw/wdata/in_valid   command to the controller (registered)
//   ctrl_busy         controller busy; a command is accepted when it is low
//   ctrl_out_valid    controller read data valid
//   ctrl_rdata        controller read data
//   grant             one-hot owner of the current transaction, 00 when idle
//   err               read-timeout pulse (optional feature)
// -----------------------------------------------------------------------------
module sdram_port_arbiter #(
  parameter int ADDR_W    = 23,
  parameter int DATA_W    = 32,
  parameter int TO_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              req0_valid,
  input  logic              req0_we,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  output logic              req0_ack,
  output logic [DATA_W-1:0] req0_rdata,

  input  logic              req1_valid,
  input  logic              req1_we,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              req1_ack,
  output logic [DATA_W-1:0] req1_rdata,

  output logic [ADDR_W-1:0] ctrl_addr,
  output logic              ctrl_rw,
  output logic [DATA_W-1:0] ctrl_wdata,
  output logic              ctrl_in_valid,
  input  logic              ctrl_busy,
  input  logic              ctrl_out_valid,
  input  logic [DATA_W-1:0] ctrl_rdata,

  output logic [1:0]        grant,
  output logic              err
);

  // Catch nonsensical configurations at elaboration time.
  if (ADDR_W < 1 || DATA_W < 1 || TO_CYCLES < 1) begin : g_bad_params
    $error("sdram_port_arbiter: ADDR_W, DATA_W and TO_CYCLES must all be >= 1");
  end

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT_RD = 2'd2,
    DONE    = 2'd3
  } state_e;

  state_e              state_q,         state_d;
  logic [1:0]          grant_q,         grant_d;
  logic                lp_q,            lp_d;        // last port that was served
  logic [ADDR_W-1:0]   ctrl_addr_q,     ctrl_addr_d;
  logic                ctrl_rw_q,       ctrl_rw_d;
  logic [DATA_W-1:0]   ctrl_wdata_q,    ctrl_wdata_d;
  logic                ctrl_in_valid_q, ctrl_in_valid_d;
  logic                ack0_q,          ack0_d;
  logic                ack1_q,          ack1_d;
  logic [DATA_W-1:0]   rdata0_q,        rdata0_d;
  logic [DATA_W-1:0]   rdata1_q,        rdata1_d;
  logic                win_port;                     // 0 = port 0, 1 = port 1

`ifdef SDRAM_ARB_TIMEOUT_EN
  localparam int               CNT_W        = $clog2(TO_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST     = CNT_W'(TO_CYCLES - 1);
  localparam logic [31:0]      TIMEOUT_WORD = 32'hDEAD_BEEF;

  logic [CNT_W-1:0] to_cnt_q, to_cnt_d;
  logic             err_q,    err_d;
`endif

  // Arbitration: a lone requester always wins; on a tie the port that was
  // not served last wins, so neither port can starve the other.
  always_comb begin
    win_port = req1_valid;
    if (req0_valid && req1_valid) begin
      win_port = ~lp_q;
    end
  end

  always_comb begin
    // NOTE: every _d starts from a hold/idle default so that no path through
    // the case statement leaves a signal unassigned (which would infer a latch).
    state_d         = state_q;
    grant_d         = grant_q;
    lp_d            = lp_q;
    ctrl_addr_d     = ctrl_addr_q;
    ctrl_rw_d       = ctrl_rw_q;
    ctrl_wdata_d    = ctrl_wdata_q;
    ctrl_in_valid_d = ctrl_in_valid_q;
    ack0_d          = 1'b0;
    ack1_d          = 1'b0;
    rdata0_d        = rdata0_q;
    rdata1_d        = rdata1_q;
`ifdef SDRAM_ARB_TIMEOUT_EN
    to_cnt_d        = to_cnt_q;
    err_d           = 1'b0;
`endif

    unique case (state_q)
      // Requests are only looked at here; once a port wins, its fields are
      // frozen in the ctrl_* registers for the rest of the transaction.
      IDLE: begin
        if (req0_valid || req1_valid) begin
          grant_d         = win_port ? 2'b10 : 2'b01;
          ctrl_addr_d     = win_port ? req1_addr  : req0_addr;
          ctrl_rw_d       = win_port ? req1_we    : req0_we;
          ctrl_wdata_d    = win_port ? req1_wdata : req0_wdata;
          ctrl_in_valid_d = 1'b1;
          state_d         = ISSUE;
        end
      end

      // The first cycle with ctrl_busy low is the accept. A write is complete
      // at that point, so its ack is registered on the way into DONE.
      ISSUE: begin
        if (!ctrl_busy) begin
          ctrl_in_valid_d = 1'b0;
          if (ctrl_rw_q) begin
            ack0_d  = grant_q[0];
            ack1_d  = grant_q[1];
            state_d = DONE;
          end else begin
            state_d = WAIT_RD;
`ifdef SDRAM_ARB_TIMEOUT_EN
            to_cnt_d = '0;
`endif
          end
        end
      end

      // Read data goes only into the granted port's register; the other
      // port's rdata keeps its previous value.
      WAIT_RD: begin
        if (ctrl_out_valid) begin
          ack0_d  = grant_q[0];
          ack1_d  = grant_q[1];
          state_d = DONE;
          if (grant_q[1]) begin
            rdata1_d = ctrl_rdata;
          end else begin
            rdata0_d = ctrl_rdata;
          end
        end
`ifdef SDRAM_ARB_TIMEOUT_EN
        // Count reaches TO_CYCLES on this cycle: give up and complete with
        // a recognisable poison word.
        else if (to_cnt_q == CNT_LAST) begin
          ack0_d  = grant_q[0];
          ack1_d  = grant_q[1];
          err_d   = 1'b1;
          state_d = DONE;
          if (grant_q[1]) begin
            rdata1_d = DATA_W'(TIMEOUT_WORD);
          end else begin
            rdata0_d = DATA_W'(TIMEOUT_WORD);
          end
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
`endif
      end

      // The ack is high during this cycle. Record the winner for the next
      // tie and release the grant; the return to IDLE guarantees at least
      // one idle cycle between transactions.
      DONE: begin
        lp_d    = grant_q[1];
        grant_d = 2'b00;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state is updated only with non-blocking assignments so
    // every flop samples the values from before this edge.
    if (rst) begin
      state_q         <= IDLE;
      grant_q         <= 2'b00;
      lp_q            <= 1'b1;      // port 0 wins the first tie
      ctrl_addr_q     <= '0;
      ctrl_rw_q       <= 1'b0;
      ctrl_wdata_q    <= '0;
      ctrl_in_valid_q <= 1'b0;
      ack0_q          <= 1'b0;
      ack1_q          <= 1'b0;
      rdata0_q        <= '0;
      rdata1_q        <= '0;
`ifdef SDRAM_ARB_TIMEOUT_EN
      to_cnt_q        <= '0;
      err_q           <= 1'b0;
`endif
    end else begin
      state_q         <= state_d;
      grant_q         <= grant_d;
      lp_q            <= lp_d;
      ctrl_addr_q     <= ctrl_addr_d;
      ctrl_rw_q       <= ctrl_rw_d;
      ctrl_wdata_q    <= ctrl_wdata_d;
      ctrl_in_valid_q <= ctrl_in_valid_d;
      ack0_q          <= ack0_d;
      ack1_q          <= ack1_d;
      rdata0_q        <= rdata0_d;
      rdata1_q        <= rdata1_d;
`ifdef SDRAM_ARB_TIMEOUT_EN
      to_cnt_q        <= to_cnt_d;
      err_q           <= err_d;
`endif
    end
  end

  assign req0_ack      = ack0_q;
  assign req1_ack      = ack1_q;
  assign req0_rdata    = rdata0_q;
  assign req1_rdata    = rdata1_q;
  assign ctrl_addr     = ctrl_addr_q;
  assign ctrl_rw       = ctrl_rw_q;
  assign ctrl_wdata    = ctrl_wdata_q;
  assign ctrl_in_valid = ctrl_in_valid_q;
  assign grant         = grant_q;

`ifdef SDRAM_ARB_TIMEOUT_EN
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sdram_port_arbiter
//
// Self-checking bench for sdram_port_arbiter. Every transaction the bench
// starts pushes its expected controller command and (if it should complete)
// its expected ack onto scoreboard queues; a monitor pops and compares them
// when the DUT issues the command or pulses an ack. Scenario tasks add
// cycle-exact checks of their own.
// Inputs are driven 1 ns after posedge; outputs are sampled on negedge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_sdram_port_arbiter;

  localparam int ADDR_W    = 23;
  localparam int DATA_W    = 32;
  localparam int TO_CYCLES = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              req0_valid = 1'b0;
  logic              req0_we    = 1'b0;
  logic [ADDR_W-1:0] req0_addr  = '0;
  logic [DATA_W-1:0] req0_wdata = '0;
  logic              req0_ack;
  logic [DATA_W-1:0] req0_rdata;
  logic              req1_valid = 1'b0;
  logic              req1_we    = 1'b0;
  logic [ADDR_W-1:0] req1_addr  = '0;
  logic [DATA_W-1:0] req1_wdata = '0;
  logic              req1_ack;
  logic [DATA_W-1:0] req1_rdata;
  logic [ADDR_W-1:0] ctrl_addr;
  logic              ctrl_rw;
  logic [DATA_W-1:0] ctrl_wdata;
  logic              ctrl_in_valid;
  logic              ctrl_busy      = 1'b0;
  logic              ctrl_out_valid = 1'b0;
  logic [DATA_W-1:0] ctrl_rdata     = '0;
  logic [1:0]        grant;
  logic              err;

  sdram_port_arbiter #(
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .TO_CYCLES(TO_CYCLES)
  ) u_dut (
    .clk           (clk),
    .rst           (rst),
    .req0_valid    (req0_valid),
    .req0_we       (req0_we),
    .req0_addr     (req0_addr),
    .req0_wdata    (req0_wdata),
    .req0_ack      (req0_ack),
    .req0_rdata    (req0_rdata),
    .req1_valid    (req1_valid),
    .req1_we       (req1_we),
    .req1_addr     (req1_addr),
    .req1_wdata    (req1_wdata),
    .req1_ack      (req1_ack),
    .req1_rdata    (req1_rdata),
    .ctrl_addr     (ctrl_addr),
    .ctrl_rw       (ctrl_rw),
    .ctrl_wdata    (ctrl_wdata),
    .ctrl_in_valid (ctrl_in_valid),
    .ctrl_busy     (ctrl_busy),
    .ctrl_out_valid(ctrl_out_valid),
    .ctrl_rdata    (ctrl_rdata),
    .grant         (grant),
    .err           (err)
  );

  initial begin
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic              rw;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } cmd_t;

  typedef struct {
    int                port;
    logic [DATA_W-1:0] rdata;
    logic              err;
  } ack_t;

  cmd_t              exp_cmd_q[$];
  ack_t              exp_ack_q[$];
  logic [DATA_W-1:0] model_rdata [2];
  int                checks = 0;
  int                errors = 0;
  int                n_cmd  = 0;
  int                n_ack0 = 0;
  int                n_ack1 = 0;

  // Advance to just after the next rising edge (input drive point).
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Record what the DUT must do for one transaction. A read updates the
  // bench's model of that port's rdata register; a write leaves it unchanged.
  task automatic expect_txn(input int port, input logic we,
                            input logic [ADDR_W-1:0] addr,
                            input logic [DATA_W-1:0] wdata,
                            input logic [DATA_W-1:0] rdata,
                            input logic with_ack, input logic err_exp);
    cmd_t c;
    ack_t a;
    c.rw    = we;
    c.addr  = addr;
    c.wdata = wdata;
    exp_cmd_q.push_back(c);
    if (with_ack) begin
      if (!we) model_rdata[port] = rdata;
      a.port  = port;
      a.rdata = model_rdata[port];
      a.err   = err_exp;
      exp_ack_q.push_back(a);
    end
  endtask

  task automatic drive_req(input int port, input logic we,
                           input logic [ADDR_W-1:0] addr,
                           input logic [DATA_W-1:0] wdata);
    if (port == 0) begin
      req0_valid = 1'b1; req0_we = we; req0_addr = addr; req0_wdata = wdata;
    end else begin
      req1_valid = 1'b1; req1_we = we; req1_addr = addr; req1_wdata = wdata;
    end
  endtask

  // Bounded waits; they return at the negedge of the event cycle.
  task automatic wait_accept(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (ctrl_in_valid && !ctrl_busy) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_ack(input int port, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if ((port == 0 && req0_ack) || (port == 1 && req1_ack)) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Scoreboard monitor: compares every accepted command and every ack.
  task automatic monitor();
    cmd_t c;
    ack_t a;
    int   port;
    logic [DATA_W-1:0] rd;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (ctrl_in_valid && !ctrl_busy) begin
          n_cmd++;
          checks++;
          if (exp_cmd_q.size() == 0) begin
            errors++;
            $display("FAIL cmd_unexpected: got rw=%0b addr=%h, expected no command", ctrl_rw, ctrl_addr);
          end else begin
            c = exp_cmd_q.pop_front();
            if (ctrl_rw !== c.rw || ctrl_addr !== c.addr || (c.rw && ctrl_wdata !== c.wdata)) begin
              errors++;
              $display("FAIL cmd_fields: got rw=%0b addr=%h wdata=%h, expected rw=%0b addr=%h wdata=%h",
                       ctrl_rw, ctrl_addr, ctrl_wdata, c.rw, c.addr, c.wdata);
            end
          end
        end
        if (req0_ack || req1_ack) begin
          port = req1_ack ? 1 : 0;
          rd   = req1_ack ? req1_rdata : req0_rdata;
          if (req0_ack) n_ack0++;
          if (req1_ack) n_ack1++;
          checks++;
          if (req0_ack && req1_ack) begin
            errors++;
            $display("FAIL ack_both: got req0_ack=1 req1_ack=1, expected one-hot");
          end else if (exp_ack_q.size() == 0) begin
            errors++;
            $display("FAIL ack_unexpected: got ack on port %0d, expected none", port);
          end else begin
            a = exp_ack_q.pop_front();
            if (port != a.port || rd !== a.rdata || err !== a.err ||
                grant !== ((a.port == 1) ? 2'b10 : 2'b01)) begin
              errors++;
              $display("FAIL ack_fields: got port=%0d rdata=%h err=%0b grant=%b, expected port=%0d rdata=%h err=%0b",
                       port, rd, err, grant, a.port, a.rdata, a.err);
            end
          end
        end else begin
          checks++;
          if (err !== 1'b0) begin
            errors++;
            $display("FAIL err_without_ack: got err=%0b, expected 0", err);
          end
        end
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (grant !== 2'b00 || req0_ack !== 1'b0 || req1_ack !== 1'b0 ||
        ctrl_in_valid !== 1'b0 || err !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got grant=%b ack0=%b ack1=%b in_valid=%b err=%b, expected all 0",
               grant, req0_ack, req1_ack, ctrl_in_valid, err);
    end
    checks++;
    if (ctrl_addr !== '0 || ctrl_wdata !== '0 || ctrl_rw !== 1'b0 ||
        req0_rdata !== '0 || req1_rdata !== '0) begin
      errors++;
      $display("FAIL reset_data: got addr=%h wdata=%h rw=%b rd0=%h rd1=%h, expected all 0",
               ctrl_addr, ctrl_wdata, ctrl_rw, req0_rdata, req1_rdata);
    end
    model_rdata[0] = '0;
    model_rdata[1] = '0;
    tick();
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (ctrl_in_valid !== 1'b0 || grant !== 2'b00) begin
      errors++;
      $display("FAIL reset_idle: got in_valid=%b grant=%b, expected 0/00", ctrl_in_valid, grant);
    end
  endtask

  task automatic test_write_latency();
    tick();                                   // cycle 0
    drive_req(0, 1'b1, 23'h000010, 32'hA5A5_0001);
    expect_txn(0, 1'b1, 23'h000010, 32'hA5A5_0001, '0, 1'b1, 1'b0);
    @(negedge clk);
    checks++;
    if (ctrl_in_valid !== 1'b0) begin
      errors++;
      $display("FAIL wr_cycle0: got in_valid=%b, expected 0", ctrl_in_valid);
    end
    @(negedge clk);                           // cycle 1
    checks++;
    if (ctrl_in_valid !== 1'b1 || ctrl_rw !== 1'b1 || ctrl_addr !== 23'h000010 ||
        ctrl_wdata !== 32'hA5A5_0001 || grant !== 2'b01) begin
      errors++;
      $display("FAIL wr_cycle1: got in_valid=%b rw=%b addr=%h wdata=%h grant=%b, expected 1/1/000010/a5a50001/01",
               ctrl_in_valid, ctrl_rw, ctrl_addr, ctrl_wdata, grant);
    end
    @(negedge clk);                           // cycle 2
    checks++;
    if (req0_ack !== 1'b1 || req1_ack !== 1'b0) begin
      errors++;
      $display("FAIL wr_cycle2_ack: got ack0=%b ack1=%b, expected 1/0", req0_ack, req1_ack);
    end
    tick();
    req0_valid = 1'b0;
    @(negedge clk);                           // cycle 3
    checks++;
    if (req0_ack !== 1'b0 || grant !== 2'b00) begin
      errors++;
      $display("FAIL wr_cycle3: got ack0=%b grant=%b, expected 0/00", req0_ack, grant);
    end
  endtask

  task automatic test_read_port1();
    bit ok;
    tick();
    drive_req(1, 1'b0, 23'h000020, 32'hFFFF_FFFF);
    expect_txn(1, 1'b0, 23'h000020, '0, 32'h1234_5678, 1'b1, 1'b0);
    wait_accept(20, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL rd_accept: got no accept in 20 cycles, expected one");
    end
    for (int i = 1; i <= 5; i++) begin
      @(posedge clk);
      #1;
      if (i == 5) begin
        ctrl_out_valid = 1'b1;
        ctrl_rdata     = 32'h1234_5678;
      end
      @(negedge clk);
      checks++;
      if (req0_ack !== 1'b0 || req1_ack !== 1'b0) begin
        errors++;
        $display("FAIL rd_early_ack: got ack0=%b ack1=%b at accept+%0d, expected 0/0", req0_ack, req1_ack, i);
      end
    end
    tick();
    ctrl_out_valid = 1'b0;
    ctrl_rdata     = 32'h0BAD_0BAD;
    @(negedge clk);
    checks++;
    if (req1_ack !== 1'b1 || req0_ack !== 1'b0 || req1_rdata !== 32'h1234_5678) begin
      errors++;
      $display("FAIL rd_ack: got ack1=%b ack0=%b rdata1=%h, expected 1/0/12345678",
               req1_ack, req0_ack, req1_rdata);
    end
    tick();
    req1_valid = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (req1_ack !== 1'b0 || req1_rdata !== 32'h1234_5678) begin
      errors++;
      $display("FAIL rd_hold: got ack1=%b rdata1=%h, expected 0/12345678", req1_ack, req1_rdata);
    end
  endtask

  task automatic drive_port_writes(input int port);
    bit ok;
    for (int k = 0; k < 4; k++) begin
      if (port == 0) drive_req(0, 1'b1, ADDR_W'(32'h100 + k), 32'hA000_0000 + k);
      else           drive_req(1, 1'b1, ADDR_W'(32'h200 + k), 32'hB000_0000 + k);
      wait_ack(port, 40, ok);
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL rr_ack_timeout: got no ack for port %0d write %0d, expected one", port, k);
      end
      tick();
    end
    if (port == 0) req0_valid = 1'b0;
    else           req1_valid = 1'b0;
  endtask

  task automatic test_round_robin();
    int a0, a1;
    for (int k = 0; k < 4; k++) begin
      expect_txn(0, 1'b1, ADDR_W'(32'h100 + k), 32'hA000_0000 + k, '0, 1'b1, 1'b0);
      expect_txn(1, 1'b1, ADDR_W'(32'h200 + k), 32'hB000_0000 + k, '0, 1'b1, 1'b0);
    end
    a0 = n_ack0;
    a1 = n_ack1;
    tick();
    fork
      drive_port_writes(0);
      drive_port_writes(1);
    join
    @(negedge clk);
    checks++;
    if (n_ack0 - a0 != 4 || n_ack1 - a1 != 4) begin
      errors++;
      $display("FAIL rr_ack_count: got %0d/%0d acks, expected 4/4", n_ack0 - a0, n_ack1 - a1);
    end
  endtask

  task automatic test_busy_stall();
    int c0;
    c0 = n_cmd;
    tick();                                   // cycle 0
    ctrl_busy = 1'b1;
    drive_req(0, 1'b1, 23'h000040, 32'h5555_AAAA);
    expect_txn(0, 1'b1, 23'h000040, 32'h5555_AAAA, '0, 1'b1, 1'b0);
    @(negedge clk);
    for (int i = 1; i <= 6; i++) begin        // cycles 1..6, busy high
      @(negedge clk);
      checks++;
      if (ctrl_in_valid !== 1'b1 || ctrl_rw !== 1'b1 || ctrl_addr !== 23'h000040 ||
          ctrl_wdata !== 32'h5555_AAAA || grant !== 2'b01 || req0_ack !== 1'b0) begin
        errors++;
        $display("FAIL busy_hold: cycle %0d got in_valid=%b rw=%b addr=%h wdata=%h grant=%b ack0=%b, expected 1/1/000040/5555aaaa/01/0",
                 i, ctrl_in_valid, ctrl_rw, ctrl_addr, ctrl_wdata, grant, req0_ack);
      end
    end
    tick();                                   // cycle 7, accept
    ctrl_busy = 1'b0;
    @(negedge clk);
    checks++;
    if (ctrl_in_valid !== 1'b1) begin
      errors++;
      $display("FAIL busy_accept: got in_valid=%b, expected 1", ctrl_in_valid);
    end
    @(negedge clk);                           // cycle 8
    checks++;
    if (req0_ack !== 1'b1 || ctrl_in_valid !== 1'b0) begin
      errors++;
      $display("FAIL busy_ack: got ack0=%b in_valid=%b, expected 1/0", req0_ack, ctrl_in_valid);
    end
    tick();
    req0_valid = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (n_cmd - c0 != 1) begin
      errors++;
      $display("FAIL busy_cmd_count: got %0d commands, expected 1", n_cmd - c0);
    end
  endtask

  task automatic test_requester_drop();
    tick();                                   // cycle 0
    drive_req(0, 1'b0, 23'h000300, 32'h0);
    expect_txn(0, 1'b0, 23'h000300, '0, 32'hCAFE_0042, 1'b1, 1'b0);
    tick();                                   // cycle 1: ISSUE, request withdrawn
    req0_valid = 1'b0;
    tick();                                   // cycle 2: WAIT_RD
    ctrl_out_valid = 1'b1;
    ctrl_rdata     = 32'hCAFE_0042;
    tick();                                   // cycle 3: DONE
    ctrl_out_valid = 1'b0;
    ctrl_rdata     = '0;
    @(negedge clk);
    checks++;
    if (req0_ack !== 1'b1 || req0_rdata !== 32'hCAFE_0042) begin
      errors++;
      $display("FAIL drop_ack: got ack0=%b rdata0=%h, expected 1/cafe0042", req0_ack, req0_rdata);
    end
    @(negedge clk);
    checks++;
    if (req0_ack !== 1'b0 || req0_rdata !== 32'hCAFE_0042 || ctrl_in_valid !== 1'b0) begin
      errors++;
      $display("FAIL drop_after: got ack0=%b rdata0=%h in_valid=%b, expected 0/cafe0042/0",
               req0_ack, req0_rdata, ctrl_in_valid);
    end
  endtask

  task automatic test_reset_mid_read();
    bit ok;
    tick();
    drive_req(1, 1'b0, 23'h000080, 32'h0);
    expect_txn(1, 1'b0, 23'h000080, '0, '0, 1'b0, 1'b0);
    wait_accept(20, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL rst_accept: got no accept in 20 cycles, expected one");
    end
    tick();                                   // WAIT_RD
    tick();
    rst        = 1'b1;
    req1_valid = 1'b0;
    tick();
    rst = 1'b0;
    model_rdata[0] = '0;
    model_rdata[1] = '0;
    @(negedge clk);
    checks++;
    if (grant !== 2'b00 || ctrl_in_valid !== 1'b0 || req0_ack !== 1'b0 || req1_ack !== 1'b0 ||
        req0_rdata !== '0 || req1_rdata !== '0) begin
      errors++;
      $display("FAIL rst_state: got grant=%b in_valid=%b ack0=%b ack1=%b rd0=%h rd1=%h, expected 00/0/0/0/0/0",
               grant, ctrl_in_valid, req0_ack, req1_ack, req0_rdata, req1_rdata);
    end
    // A stray ctrl_out_valid outside WAIT_RD must be ignored.
    tick();
    ctrl_out_valid = 1'b1;
    ctrl_rdata     = 32'h7777_7777;
    tick();
    ctrl_out_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (req0_ack !== 1'b0 || req1_ack !== 1'b0 || grant !== 2'b00 || req1_rdata !== '0) begin
        errors++;
        $display("FAIL rst_stray: got ack0=%b ack1=%b grant=%b rd1=%h, expected 0/0/00/0",
                 req0_ack, req1_ack, grant, req1_rdata);
      end
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    expect_txn(1, 1'b1, 23'h000400, 32'h1111_0001, '0, 1'b1, 1'b0);
    expect_txn(1, 1'b1, 23'h000404, 32'h1111_0002, '0, 1'b1, 1'b0);
    tick();
    drive_req(1, 1'b1, 23'h000400, 32'h1111_0001);
    wait_ack(1, 20, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL b2b_ack1: got no ack in 20 cycles, expected one");
    end
    tick();                                   // IDLE cycle after DONE
    drive_req(1, 1'b1, 23'h000404, 32'h1111_0002);
    @(negedge clk);
    checks++;
    if (ctrl_in_valid !== 1'b0 || grant !== 2'b00) begin
      errors++;
      $display("FAIL b2b_gap: got in_valid=%b grant=%b, expected 0/00", ctrl_in_valid, grant);
    end
    @(negedge clk);
    checks++;
    if (ctrl_in_valid !== 1'b1 || ctrl_addr !== 23'h000404 || grant !== 2'b10) begin
      errors++;
      $display("FAIL b2b_issue: got in_valid=%b addr=%h grant=%b, expected 1/000404/10",
               ctrl_in_valid, ctrl_addr, grant);
    end
    wait_ack(1, 20, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL b2b_ack2: got no ack in 20 cycles, expected one");
    end
    tick();
    req1_valid = 1'b0;
  endtask

`ifdef SDRAM_ARB_TIMEOUT_EN
  task automatic test_timeout();
    bit ok;
    tick();
    drive_req(0, 1'b0, 23'h000500, 32'h0);
    expect_txn(0, 1'b0, 23'h000500, '0, 32'hDEAD_BEEF, 1'b1, 1'b1);
    wait_accept(20, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL to_accept: got no accept in 20 cycles, expected one");
    end
    // TO_CYCLES waiting cycles in WAIT_RD, then the ack cycle.
    for (int i = 1; i <= TO_CYCLES; i++) begin
      @(negedge clk);
      checks++;
      if (req0_ack !== 1'b0 || err !== 1'b0) begin
        errors++;
        $display("FAIL to_early: got ack0=%b err=%b at accept+%0d, expected 0/0", req0_ack, err, i);
      end
    end
    @(negedge clk);
    checks++;
    if (req0_ack !== 1'b1 || err !== 1'b1 || req0_rdata !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL to_ack: got ack0=%b err=%b rdata0=%h, expected 1/1/deadbeef", req0_ack, err, req0_rdata);
    end
    tick();
    req0_valid     = 1'b0;
    ctrl_out_valid = 1'b1;                    // late data must be ignored
    ctrl_rdata     = 32'h1111_1111;
    tick();
    ctrl_out_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (req0_ack !== 1'b0 || err !== 1'b0 || req0_rdata !== 32'hDEAD_BEEF) begin
        errors++;
        $display("FAIL to_late: got ack0=%b err=%b rdata0=%h, expected 0/0/deadbeef", req0_ack, err, req0_rdata);
      end
    end
  endtask
`endif

  initial begin
    fork
      monitor();
      begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within 200000 ns");
        $fatal(1, "watchdog expired");
      end
    join_none

    test_reset();
    test_write_latency();
    test_read_port1();
    test_round_robin();
    test_busy_stall();
    test_requester_drop();
    test_reset_mid_read();
    test_back_to_back();
`ifdef SDRAM_ARB_TIMEOUT_EN
    test_timeout();
`endif

    repeat (3) @(negedge clk);
    checks++;
    if (exp_cmd_q.size() != 0 || exp_ack_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d cmds / %0d acks outstanding, expected 0/0",
               exp_cmd_q.size(), exp_ack_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sdram_port_arbiter.md
Name: sdram_port_arbiter

Overview:
- Two-requester arbiter and sequencer in front of the user-area SDRAM controller (sdram_controller).
- Shares the controller's single command interface (user_addr, rw, data_in, data_out, busy, in_valid, out_valid) between the Wishbone slave path (port 0) and a second master such as a DMA/prefetch engine (port 1).
- Runs one transaction at a time, uses round-robin fairness, and registers all controller-side signals.

Parameters:
- ADDR_W, 23, request/controller address width.
- DATA_W, 32, data width.
- TO_CYCLES, 255, read-timeout limit in clk cycles. Used only with SDRAM_ARB_TIMEOUT_EN.

Ports:
- clk  input  1  single clock; all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- req0_valid  input  1  port 0 request; held until req0_ack.
- req0_we  input  1  1=write, 0=read.
- req0_addr  input  ADDR_W  port 0 address.
- req0_wdata  input  DATA_W  port 0 write data.
- req0_ack  output  1  one-cycle completion pulse.
- req0_rdata  output  DATA_W  read data, valid while req0_ack=1.
- req1_valid, req1_we, req1_addr, req1_wdata, req1_ack, req1_rdata: same as port 0, for port 1.
- ctrl_addr  output  ADDR_W  to controller user_addr.
- ctrl_rw  output  1  to controller rw.
- ctrl_wdata  output  DATA_W  to controller data_in.
- ctrl_in_valid  output  1  command strobe to controller.
- ctrl_busy  input  1  controller busy.
- ctrl_out_valid  input  1  controller read data valid.
- ctrl_rdata  input  DATA_W  controller data_out.
- grant  output  2  one-hot owner of the current transaction; 00 when idle.
- err  output  1  timeout flag pulse; tied 0 without the optional feature.

Behaviour:
- Reset (synchronous):
  - state=IDLE.
  - req0_ack, req1_ack, ctrl_in_valid, err = 0.
  - grant=00.
  - req*_rdata, ctrl_addr, ctrl_wdata = 0; ctrl_rw=0.
  - last-winner pointer lp=1, so port 0 wins the first tie.
  - Reset asserted mid-transaction aborts it: no ack is issued, and ctrl_in_valid is 0 from the next cycle.
- FSM states: IDLE, ISSUE, WAIT_RD, DONE.
- IDLE:
  - If exactly one reqN_valid is set, that port wins.
  - If both are set, the port != lp wins.
  - On a win: latch addr/we/wdata into ctrl_* regs, set grant, set ctrl_in_valid=1, go to ISSUE.
  - Request inputs are not sampled again until the next IDLE.
- ISSUE:
  - Hold ctrl_in_valid=1 and the latched fields until the first cycle with ctrl_busy=0. That cycle is the accept.
  - On accept: ctrl_in_valid=0 next cycle. A write goes to DONE; a read goes to WAIT_RD.
- WAIT_RD: on ctrl_out_valid=1, capture ctrl_rdata into the granted port's rdata register, go to DONE.
- DONE:
  - Pulse the granted reqN_ack for exactly one cycle, with reqN_rdata stable.
  - Update lp to the granted port; grant=00; go to IDLE.
  - The requester drops valid in the cycle after the ack, so the same request is not re-accepted.
- Latency, with request seen in IDLE at cycle 0 and ctrl_busy=0:
  - ctrl_in_valid high in cycle 1.
  - Write: ack in cycle 2.
  - Read: ack one cycle after ctrl_out_valid.
- Boundary cases:
  - Port 1 requesting during a port 0 transaction waits and wins the next IDLE if port 0 requests again (no starvation).
  - Requester dropping valid mid-transaction: the transaction still completes and the ack still pulses.
  - ctrl_out_valid while not in WAIT_RD: ignored.
  - req*_rdata holds its last value between acks.
- Back-to-back transactions: minimum 1 IDLE cycle between DONE and the next ISSUE.

Optional Feature:
- Macro: SDRAM_ARB_TIMEOUT_EN.
- With the macro defined:
  - WAIT_RD has a counter, cleared on entry and incremented each cycle.
  - If the count reaches TO_CYCLES with no ctrl_out_valid: rdata=32'hDEAD_BEEF, err pulses one cycle together with the ack, then go to DONE.
  - A ctrl_out_valid that arrives late is ignored.
- Without the macro: no counter, err tied 0, WAIT_RD waits indefinitely.

Test Plan:
- Port 0 write addr 0x000010, data 0xA5A5_0001, ctrl_busy=0 -> ctrl_in_valid in cycle 1 with ctrl_rw=1, ctrl_addr=0x10; req0_ack in cycle 2; grant=01 during the transaction.
- Port 1 read 0x000020; controller returns 0x1234_5678 with ctrl_out_valid 5 cycles after accept -> req1_ack one cycle later, req1_rdata=0x1234_5678; req0_ack stays 0.
- Both ports valid continuously for 4 writes each -> grants alternate 0,1,0,1...; each port receives exactly 4 acks.
- ctrl_busy held high for 6 cycles during ISSUE -> ctrl_in_valid and fields stable for all 6 cycles, accepted on the first busy=0 cycle, exactly one command issued.
- rst asserted in WAIT_RD -> next cycle: state IDLE, grant=00, no ack; a later ctrl_out_valid produces no ack.
- With SDRAM_ARB_TIMEOUT_EN and TO_CYCLES=8, read with no ctrl_out_valid -> ack and err together after 8 cycles, rdata=0xDEAD_BEEF.
